// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S microphone controller.
// A frame is two 32-bit slots, left (word select low) then right.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN,
    STOP
  } i2s_state_t;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int IDX_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: SCK level, registered edge strobes and frame bit index.
// Everything clears to SCK low, index 0, when run_i is low.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  output logic             sck_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [IDX_W-1:0] bit_idx_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             term;

  assign term = (div_q == DIV_W'(CLK_DIV - 1));

  // Strobes are registered with the SCK toggle so they mark its new level.
  always_comb begin
    div_d  = div_q;
    sck_d  = sck_q;
    idx_d  = idx_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!run_i) begin
      div_d = '0;
      sck_d = 1'b0;
      idx_d = '0;
    end else if (term) begin
      div_d  = '0;
      sck_d  = ~sck_q;
      rise_d = ~sck_q;
      fall_d = sck_q;
      if (sck_q) begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      div_q  <= div_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      idx_q  <= idx_d;
    end
  end

  assign sck_o     = sck_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign bit_idx_o = idx_q;

endmodule

// File: rtl/i2s_mic_ctrl.sv
// Master-mode I2S microphone controller: clocks, warm-up/run/stop
// sequencing, slot deserialiser and valid/ready sample output.
module i2s_mic_ctrl
  import i2s_pkg::*;
#(
  parameter int CLK_DIV       = 16,
  parameter int SAMPLE_BITS   = 18,
  parameter int CHANNEL       = 0,
  parameter int WARMUP_FRAMES = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   mic_data_in,
  output logic                   i2s_clk_out,
  output logic                   lrcl_clk_out,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic                   sample_valid_out,
  input  logic                   sample_ready_in,
  output logic                   overrun_out,
  output logic                   busy_out
);

  localparam int SLOT_BASE = SLOT_BITS * CHANNEL;
  localparam int FC_W      = $clog2(WARMUP_FRAMES + 1);

  // One-bit delay after the word-select edge before the MSB.
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(SLOT_BASE + 1);
  localparam logic [IDX_W-1:0] LSB_IDX = IDX_W'(SLOT_BASE + SAMPLE_BITS);
  localparam logic [FC_W-1:0]  WARM_LAST = FC_W'(WARMUP_FRAMES - 1);

  i2s_state_t state_q, state_d;

  logic             run;
  logic             sck;
  logic             rise;
  logic             fall;
  logic [IDX_W-1:0] bit_idx;
  logic             wrap;
  logic             warm_done;
  logic             in_slot;
  logic             deliver;

  logic [FC_W-1:0]        frame_q, frame_d;
  logic                   from_run_q, from_run_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic                   lsb_q, lsb_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;

  i2s_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .run_i    (run),
    .sck_o    (sck),
    .rise_o   (rise),
    .fall_o   (fall),
    .bit_idx_o(bit_idx)
  );

  assign wrap      = fall && (bit_idx == '0);
  assign warm_done = wrap && (frame_q == WARM_LAST);
  assign in_slot   = rise && (bit_idx >= MSB_IDX)
                          && (bit_idx <= LSB_IDX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = WARMUP;
      end
      WARMUP: begin
        if (!enable_in)     state_d = STOP;
        else if (warm_done) state_d = RUN;
      end
      RUN: begin
        if (!enable_in) state_d = STOP;
      end
      STOP: begin
        if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider follows the next state so IDLE always sees it frozen at 0.
  always_comb begin
    busy_out = (state_q != IDLE);
    run      = (state_d != IDLE);
  end

  always_comb begin
    frame_d = '0;
    if (state_q == WARMUP) begin
      frame_d = wrap ? frame_q + 1'b1 : frame_q;
    end
  end

  assign from_run_d = (state_q == RUN)
                   || (from_run_q && state_q != IDLE);

  assign shift_d = in_slot
                 ? SAMPLE_BITS'({shift_q, mic_data_in})
                 : shift_q;
  assign lsb_d   = rise && (bit_idx == LSB_IDX);

  // Samples finishing in STOP count only if the stop came from RUN.
  assign deliver = lsb_q
                && ((state_q == RUN)
                 || (state_q == STOP && from_run_q));

  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (valid_q && sample_ready_in) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || sample_ready_in) begin
        sample_d = shift_q;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (state_q == IDLE && enable_in) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_q    <= '0;
      from_run_q <= 1'b0;
      shift_q    <= '0;
      lsb_q      <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      from_run_q <= from_run_d;
      shift_q    <= shift_d;
      lsb_q      <= lsb_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign i2s_clk_out      = sck;
  assign lrcl_clk_out     = bit_idx[IDX_W-1];
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = ovr_q;

endmodule

// File: doc/i2s_mic_ctrl.md
Name: i2s_mic_ctrl

Overview:
Master-mode controller for the on-board I2S MEMS microphone. It generates the bit clock (SCK) and word-select (LRCL) from the system clock, and sequences power-up warm-up, run and clean stop. It deserialises the selected channel slot and hands signed samples to the downstream audio pipeline over a valid/ready handshake, flagging any samples dropped because of back-pressure.

Parameters:
CLK_DIV, 16, SCK half-period in clk_in cycles (100 MHz / 32 = 3.125 MHz SCK); legal values are 2 or more
SAMPLE_BITS, 18, significant bits per slot, MSB first; legal range is 1–31
CHANNEL, 0, captured slot: 0 = left (LRCL low), 1 = right (LRCL high)
WARMUP_FRAMES, 4096, full frames discarded after enable before samples are delivered; legal values are 1 or more

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
enable_in  input  1  level: run the microphone
mic_data_in  input  1  serial data from the microphone
i2s_clk_out  output  1  SCK to the microphone
lrcl_clk_out  output  1  word select to the microphone
sample_out  output  SAMPLE_BITS  signed sample, two's complement
sample_valid_out  output  1  sample_out holds an undelivered sample
sample_ready_in  input  1  downstream accepts the sample
overrun_out  output  1  sticky: a completed sample was dropped
busy_out  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock clk_in. rst_n_in is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE, WARMUP, RUN, STOP.
- IDLE: SCK and LRCL held low, divider and bit counter frozen at 0. If enable_in=1, go to WARMUP on the next cycle and clear overrun_out.
- Divider: div_cnt counts 0..CLK_DIV-1. At terminal count, SCK toggles.
  - rise strobe = cycle where SCK goes 0→1.
  - fall strobe = cycle where SCK goes 1→0.
  - Strobes are internal single-cycle pulses aligned to the registered SCK change.
- Frame: bit_idx 0..63 advances on each fall strobe and wraps 63→0. LRCL = bit_idx[5], updated on the fall strobe, so LRCL changes only on SCK falling edges.
- Capture: mic_data_in is sampled on the rise strobe.
  - Slot base B = 32·CHANNEL.
  - Data MSB is sampled at bit_idx = B+1; LSB at bit_idx = B+SAMPLE_BITS. This is the standard I2S one-bit delay after the LRCL edge.
  - Other bits are ignored.
- Delivery: on the cycle after the LSB rise strobe, in RUN or STOP:
  - If sample_valid_out=0, or sample_ready_in=1 in the same cycle: load sample_out and assert sample_valid_out.
  - Otherwise keep the old sample and set overrun_out.
- Handshake:
  - A transfer occurs on a cycle with valid&&ready.
  - sample_valid_out drops the next cycle unless it is reloaded in that same cycle.
  - sample_out is stable while valid && !ready.
- WARMUP: clocks run and captures are discarded. frame_cnt increments at each 63→0 wrap. At WARMUP_FRAMES wraps, go to RUN. The first delivered sample comes from the frame starting at that wrap.
- RUN → STOP when enable_in=0.
- WARMUP with enable_in=0 → STOP.
- STOP:
  - Clocks continue to the end of the current frame.
  - Samples completing in STOP are delivered only if the previous state was RUN.
  - At the fall strobe that wraps bit_idx 63→0, go to IDLE with SCK=0, LRCL=0 and counters cleared.
- enable_in re-asserted during STOP is ignored until IDLE, then re-enters WARMUP normally.
- Reset mid-frame: everything returns to reset values immediately, including a pending valid sample, which is lost.
- overrun_out is cleared only by reset or the IDLE→WARMUP transition.

Decomposition:
- Package i2s_pkg:
  - typedef enum logic [1:0] {IDLE, WARMUP, RUN, STOP} i2s_state_t
  - localparams FRAME_BITS=64 and SLOT_BITS=32
- One sub-module, i2s_sck_gen:
  - Divider with run input.
  - Outputs: SCK level, rise/fall strobes, and bit_idx.
  - Clears to SCK low when run=0.

Test Plan (CLK_DIV=2, WARMUP_FRAMES=2, SAMPLE_BITS=18 unless noted):
1. Reset, enable_in=1 held → SCK period 4 clk_in; LRCL toggles every 32 SCK falling edges; sample_valid_out stays 0 for the first 2 frames and first pulses in frame 3.
2. Model drives left slot 0x2ABCD (MSB at bit_idx 1), right slot 0x15432, CHANNEL=0, sample_ready_in=1 → sample_out=0x2ABCD (negative) each frame. Rerun with CHANNEL=1 → sample_out=0x15432.
3. sample_ready_in=0 across two completed samples → sample_out keeps the first value, overrun_out=1. Ready then pulses for 1 cycle → valid drops next cycle; overrun_out stays 1.
4. enable_in dropped mid-RUN at bit_idx 10 → busy_out stays high to the end of the frame; left sample of that frame still delivered. Then SCK=0, LRCL=0, busy_out=0.
5. rst_n_in pulsed low mid-slot with valid pending → all outputs 0 asynchronously. After release with enable_in=1, a full 2-frame warm-up repeats and overrun_out=0.
6. enable_in toggled 1→0→1 within STOP → block completes the frame, passes through IDLE for 1 cycle, re-enters WARMUP and clears overrun_out.
